fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, in-order imem requests, and a
// 2-entry (pc, instr) buffer toward decode, with redirect flush and fault stop.

module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   assign y = a + b;
endmodule

module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            if_ready,
   output logic            fetch_fault
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both
   // high; once raised, the payload is stable until the transfer completes.

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_inc;
   logic [1:0]      outstanding;
   logic [1:0]      drop_cnt;
   logic [1:0]      occ;
   logic [1:0]      tag_cnt;
   logic [XLEN-1:0] buf_pc  [2];
   logic [XLEN-1:0] buf_ins [2];
   logic [XLEN-1:0] tag_q   [2];

   logic       pop;
   logic       accept;
   logic       redir;
   logic       drop;
   logic       push;
   logic       tag_push;
   logic [2:0] credit;
   logic [1:0] out_next;
   logic [1:0] occ_after_pop;
   logic [1:0] tag_after_pop;
   logic       buf_wr_idx;
   logic       tag_wr_idx;

   adder u_pc_adder (
      .a (pc),
      .b (32'h4),
      .y (pc_inc)
   );

   assign if_valid      = (occ != 2'd0);
   assign if_pc         = buf_pc[0];
   assign if_instr      = buf_ins[0];
   assign imem_req_addr = pc;

   // Requests in flight plus buffered entries never exceed the two buffer slots,
   // so every non-dropped response is guaranteed a place.
   assign pop            = if_valid & if_ready;
   assign credit         = {1'b0, outstanding} + {1'b0, occ} - {2'b00, pop};
   assign imem_req_valid = (state == RUN) && (credit < 3'd2);
   assign accept         = imem_req_valid & imem_req_ready;
   assign redir          = redirect_valid && (state != BOOT);
   assign drop           = imem_rsp_valid && (drop_cnt != 2'd0);
   assign push           = imem_rsp_valid && (drop_cnt == 2'd0) && !redir;
   assign tag_push       = accept && !redir;
   assign out_next       = outstanding + {1'b0, accept} - {1'b0, imem_rsp_valid};
   assign occ_after_pop  = occ - {1'b0, pop};
   assign tag_after_pop  = tag_cnt - {1'b0, push};
   assign buf_wr_idx     = (occ_after_pop != 2'd0);
   assign tag_wr_idx     = (tag_after_pop != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         fetch_fault <= 1'b0;
         outstanding <= 2'd0;
         drop_cnt    <= 2'd0;
         occ         <= 2'd0;
         tag_cnt     <= 2'd0;
         buf_pc[0]   <= '0;
         buf_pc[1]   <= '0;
         buf_ins[0]  <= '0;
         buf_ins[1]  <= '0;
         tag_q[0]    <= '0;
         tag_q[1]    <= '0;
      end else begin
         outstanding <= out_next;

         unique case (state)
            BOOT: state <= RUN;
            default: begin
               if (redir) begin
                  pc <= redirect_pc;
                  if (redirect_pc[1:0] != 2'b00) begin
                     state       <= FAULT;
                     fetch_fault <= 1'b1;
                  end else begin
                     state       <= RUN;
                     fetch_fault <= 1'b0;
                  end
               end else if (accept) begin
                  pc <= pc_inc;
               end
            end
         endcase

         // Everything still in memory at the end of a redirect cycle is stale.
         if (redir)
            drop_cnt <= out_next;
         else if (drop)
            drop_cnt <= drop_cnt - 2'd1;

         if (redir) begin
            occ     <= 2'd0;
            tag_cnt <= 2'd0;
         end else begin
            if (pop) begin
               buf_pc[0]  <= buf_pc[1];
               buf_ins[0] <= buf_ins[1];
            end
            if (push) begin
               assert (occ_after_pop != 2'd2);
               buf_pc[buf_wr_idx]  <= tag_q[0];
               buf_ins[buf_wr_idx] <= imem_rsp_data;
               tag_q[0]            <= tag_q[1];
            end
            occ <= occ_after_pop + {1'b0, push};
            if (tag_push)
               tag_q[tag_wr_idx] <= pc;
            tag_cnt <= tag_after_pop + {1'b0, tag_push};
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed table, corner sequences and random traffic
// against an in-order memory model and an expected-instruction scoreboard.

module tb_fetch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] XMASK  = 32'hAAAA_AAAA;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready = 1'b0;
   logic        fetch_fault;

   fetch_pc_unit #(.RESET_PC(RST_PC), .XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready),
      .fetch_fault    (fetch_fault)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        live;
      int          due;
   } mreq_t;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ifr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_ifpc;
   } vec_t;

   mreq_t       mem_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] acc_log[$];
   logic [31:0] model_pc;
   logic        model_fault;
   logic        model_boot;
   int          cycle;
   int          mem_lat;
   int          checks;
   int          failures;
   logic        cur_rv;
   logic [31:0] cur_rpc;
   logic        cur_rdy;
   logic        cur_ifr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic int buffered_cnt();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].live) n++;
      return exp_q.size() - n;
   endfunction

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if_ready       = 1'b0;
      mem_q.delete();
      exp_q.delete();
      acc_log.delete();
      model_pc    = RST_PC;
      model_fault = 1'b0;
      model_boot  = 1'b1;
      mem_lat     = 1;
      repeat (2) @(negedge clk);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      rst_n = 1'b1;
   endtask

   // driver: apply this cycle's inputs (called at a falling edge)
   task automatic drive_in(input logic rv, input logic [31:0] rpc, input logic rdy, input logic ifr);
      cur_rv = rv; cur_rpc = rpc; cur_rdy = rdy; cur_ifr = ifr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      if_ready       = ifr;
      if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].addr ^ XMASK;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
   endtask

   // scoreboard check and model update for the coming rising edge
   task automatic check_and_advance();
      int   buffered;
      int   credit;
      logic pop_e;
      logic exp_req;
      logic redir_e;
      buffered = buffered_cnt();
      chk("if_valid", 32'(if_valid), 32'(buffered > 0));
      if (buffered > 0) begin
         chk("if_pc", if_pc, exp_q[0]);
         chk("if_instr", if_instr, exp_q[0] ^ XMASK);
      end
      pop_e   = (buffered > 0) && cur_ifr;
      credit  = mem_q.size() + buffered - (pop_e ? 1 : 0);
      exp_req = !model_boot && !model_fault && (credit < 2);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, model_pc);
      chk("fetch_fault", 32'(fetch_fault), 32'(model_fault));

      redir_e = cur_rv && !model_boot;
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (pop_e) void'(exp_q.pop_front());
      if (imem_req_valid && cur_rdy) begin
         acc_log.push_back(imem_req_addr);
         mem_q.push_back('{addr: imem_req_addr, live: !redir_e, due: cycle + mem_lat});
         if (!redir_e) exp_q.push_back(model_pc);
         model_pc = model_pc + 32'd4;
      end
      if (redir_e) begin
         model_pc = cur_rpc;
         exp_q.delete();
         foreach (mem_q[i]) mem_q[i].live = 1'b0;
         model_fault = (cur_rpc[1:0] != 2'b00);
      end
      model_boot = 1'b0;
      cycle++;
      @(negedge clk);
   endtask

   task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input logic ifr);
      drive_in(rv, rpc, rdy, ifr);
      check_and_advance();
   endtask

   vec_t vt[7];

   initial begin
      logic [31:0] held_pc;
      logic [31:0] held_ins;
      logic [31:0] held_addr;
      logic        found;
      checks   = 0;
      failures = 0;
      cycle    = 0;

      // boot sequence, 1-cycle memory, decode always ready
      vt[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000};
      vt[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
      vt[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
      vt[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
      vt[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
      vt[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
      vt[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive_in(vt[i].rv, vt[i].rpc, vt[i].rdy, vt[i].ifr);
         chk("tbl_req_valid", 32'(imem_req_valid), 32'(vt[i].e_req));
         if (vt[i].e_req) chk("tbl_req_addr", imem_req_addr, vt[i].e_addr);
         chk("tbl_if_valid", 32'(if_valid), 32'(vt[i].e_ifv));
         if (vt[i].e_ifv) begin
            chk("tbl_if_pc", if_pc, vt[i].e_ifpc);
            chk("tbl_if_instr", if_instr, vt[i].e_ifpc ^ XMASK);
         end
         check_and_advance();
      end

      // backpressure: decode stalls for 5 cycles
      drive_in(1'b0, 32'h0, 1'b1, 1'b0);
      held_pc  = if_pc;
      held_ins = if_instr;
      check_and_advance();
      repeat (4) begin
         drive_in(1'b0, 32'h0, 1'b1, 1'b0);
         chk("bp_valid", 32'(if_valid), 32'd1);
         chk("bp_hold_pc", if_pc, held_pc);
         chk("bp_hold_instr", if_instr, held_ins);
         chk("bp_bound", 32'(mem_q.size() + buffered_cnt() <= 2), 32'd1);
         check_and_advance();
      end
      repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);

      // redirect while 0x108 and 0x10C are still in memory
      do_reset();
      mem_lat = 4;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mem_q.size() == 2 && mem_q[0].addr == 32'h108 && mem_q[1].addr == 32'h10C)
            found = 1'b1;
         else
            step(1'b0, 32'h0, 1'b1, 1'b1);
      end
      chk("rd_setup_reached", 32'(found), 32'd1);
      step(1'b1, 32'h200, 1'b1, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         drive_in(1'b0, 32'h0, 1'b1, 1'b1);
         if (if_valid) begin
            chk("rd_first_pc", if_pc, 32'h200);
            found = 1'b1;
         end
         check_and_advance();
      end
      chk("rd_first_seen", 32'(found), 32'd1);

      // wrap-around of the program counter
      mem_lat = 1;
      step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      acc_log.delete();
      repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("wrap_count", 32'(acc_log.size() >= 3), 32'd1);
      if (acc_log.size() >= 3) begin
         chk("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
         chk("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
         chk("wrap_addr2", acc_log[2], 32'h0000_0000);
      end

      // misaligned redirect and recovery
      step(1'b1, 32'h202, 1'b1, 1'b1);
      drive_in(1'b0, 32'h0, 1'b1, 1'b1);
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      chk("mis_no_req", 32'(imem_req_valid), 32'd0);
      check_and_advance();
      repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b1, 32'h300, 1'b1, 1'b1);
      drive_in(1'b0, 32'h0, 1'b1, 1'b1);
      chk("mis_clear", 32'(fetch_fault), 32'd0);
      chk("mis_req", 32'(imem_req_valid), 32'd1);
      chk("mis_addr", imem_req_addr, 32'h300);
      check_and_advance();

      // memory stalled for 3 cycles
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
      drive_in(1'b0, 32'h0, 1'b0, 1'b1);
      held_addr = imem_req_addr;
      chk("stall_req", 32'(imem_req_valid), 32'd1);
      check_and_advance();
      repeat (2) begin
         drive_in(1'b0, 32'h0, 1'b0, 1'b1);
         chk("stall_req", 32'(imem_req_valid), 32'd1);
         chk("stall_addr", imem_req_addr, held_addr);
         check_and_advance();
      end
      drive_in(1'b0, 32'h0, 1'b1, 1'b1);
      chk("stall_release_addr", imem_req_addr, held_addr);
      check_and_advance();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic        rv;
         logic [31:0] rpc;
         if (i % 50 == 0) mem_lat = $urandom_range(1, 3);
         rv  = ($urandom_range(0, 15) == 0);
         rpc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) rpc = 32'hFFFF_FFF0;
         if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         step(rv, rpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      end

      // asynchronous reset in the middle of traffic
      step(1'b1, 32'h400, 1'b1, 1'b1);
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_if_valid", 32'(if_valid), 32'd0);
      chk("async_req", 32'(imem_req_valid), 32'd0);
      chk("async_if_pc", if_pc, 32'h0);
      @(negedge clk);
      do_reset();
      repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cycle);
      $fatal(1);
   end

endmodule
